// File: rtl/robin_pkg.sv
// ---------------------------------------------------------------------------
// robin_pkg
//   Shared definitions for the serial monitor: command / response byte
//   constants, the monitor FSM state encoding, and a small helper that
//   recognises commands which carry an address argument.
// ---------------------------------------------------------------------------
package robin_pkg;

  // Command bytes received over the serial link
  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_DUMP = 8'h44;  // 'D'
  localparam logic [7:0] CMD_EXEC = 8'h58;  // 'X'
  localparam logic [7:0] CMD_HALT = 8'h48;  // 'H'

  // Response bytes sent back
  localparam logic [7:0] RSP_ACK  = 8'h2B;  // '+'
  localparam logic [7:0] RSP_NAK  = 8'h3F;  // '?'

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR_HI   = 4'd1,
    ADDR_LO   = 4'd2,
    LEN_HI    = 4'd3,
    LEN_LO    = 4'd4,
    LOAD      = 4'd5,
    DUMP_RD   = 4'd6,
    DUMP_WAIT = 4'd7,
    DUMP_TX   = 4'd8,
    RUN       = 4'd9,
    RUN_WAIT  = 4'd10,
    ACK       = 4'd11
  } state_t;

  // Commands that are followed by an address field
  function automatic logic takes_address(input logic [7:0] b);
    return (b == CMD_LOAD) || (b == CMD_DUMP) || (b == CMD_EXEC);
  endfunction

endpackage

// File: rtl/monitor.sv
// ---------------------------------------------------------------------------
// monitor
//   Byte-oriented debug monitor. Parses commands from a UART receiver and
//   loads memory ('L'), dumps memory ('D'), starts the cpu at an address
//   ('X') or halts it ('H'). Responses go out through a UART transmitter.
//
// Ports
//   clk, reset_n               clock, asynchronous active-low reset
//   rx_data, rx_valid          received byte + one-cycle strobe
//   tx_data, tx_start, tx_busy byte to send, one-cycle send strobe, busy
//   mem_raddr, mem_waddr       memory read / write address
//   mem_data_in, mem_data_out  write data to memory / read data from memory
//   mem_write                  memory write strobe
//   mem_sel                    1 = monitor owns the memory port, 0 = cpu
//   cpu_reset, cpu_halt        cpu control
//   cpu_halted                 cpu reports it has stopped
//   start_address              cpu start address for 'X'
// ---------------------------------------------------------------------------
module monitor
  import robin_pkg::*;
#(
  parameter int addr_width = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic [addr_width-1:0] mem_raddr,
  output logic [addr_width-1:0] mem_waddr,
  output logic [7:0]            mem_data_in,
  input  logic [7:0]            mem_data_out,
  output logic                  mem_write,
  output logic                  mem_sel,
  output logic                  cpu_reset,
  output logic                  cpu_halt,
  input  logic                  cpu_halted,
  output logic [addr_width-1:0] start_address
);

  state_t                state_reg, state_next;

  logic [7:0]            cmd_reg;
  logic [7:0]            addr_hi_reg;
  logic [7:0]            len_hi_reg;
  logic [addr_width-1:0] addr_reg;
  logic [15:0]           len_reg;
  logic [7:0]            tx_data_reg;
  logic [addr_width-1:0] mem_raddr_reg;
  logic [addr_width-1:0] mem_waddr_reg;
  logic [7:0]            mem_data_in_reg;
  logic                  mem_write_reg;
  logic [addr_width-1:0] start_address_reg;
  logic                  halt_reg;

  wire logic [15:0] len_word = {len_hi_reg, rx_data};

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (rx_valid) state_next = takes_address(rx_data) ? ADDR_HI : ACK;
      end
      ADDR_HI: if (rx_valid) state_next = ADDR_LO;
      ADDR_LO: begin
        if (rx_valid) state_next = (cmd_reg == CMD_EXEC) ? RUN : LEN_HI;
      end
      LEN_HI: if (rx_valid) state_next = LEN_LO;
      LEN_LO: begin
        if (rx_valid) begin
          if (len_word == 16'd0) state_next = (cmd_reg == CMD_LOAD) ? ACK  : IDLE;
          else                   state_next = (cmd_reg == CMD_LOAD) ? LOAD : DUMP_RD;
        end
      end
      LOAD: if (rx_valid && len_reg == 16'd1) state_next = ACK;
      DUMP_RD:   state_next = DUMP_WAIT;
      DUMP_WAIT: state_next = DUMP_TX;
      DUMP_TX: begin
        if (!tx_busy) state_next = (len_reg == 16'd1) ? IDLE : DUMP_RD;
      end
      RUN:      state_next = RUN_WAIT;
      RUN_WAIT: if (cpu_halted) state_next = ACK;
      ACK:      if (!tx_busy) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers: command fields, address / length counters, memory
  // port and transmit byte.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_reg           <= '0;
      addr_hi_reg       <= '0;
      len_hi_reg        <= '0;
      addr_reg          <= '0;
      len_reg           <= '0;
      tx_data_reg       <= '0;
      mem_raddr_reg     <= '0;
      mem_waddr_reg     <= '0;
      mem_data_in_reg   <= '0;
      mem_write_reg     <= 1'b0;
      start_address_reg <= '0;
      halt_reg          <= 1'b0;
    end else begin
      mem_write_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (rx_valid) begin
            cmd_reg <= rx_data;
            if (!takes_address(rx_data))
              tx_data_reg <= (rx_data == CMD_HALT) ? RSP_ACK : RSP_NAK;
          end
        end
        ADDR_HI: if (rx_valid) addr_hi_reg <= rx_data;
        ADDR_LO: begin
          // Upper address bits beyond the memory width are dropped
          if (rx_valid) addr_reg <= addr_width'({addr_hi_reg, rx_data});
        end
        LEN_HI: if (rx_valid) len_hi_reg <= rx_data;
        LEN_LO: begin
          if (rx_valid) begin
            len_reg <= len_word;
            if (len_word == 16'd0) tx_data_reg <= RSP_ACK;
          end
        end
        LOAD: begin
          if (rx_valid) begin
            mem_write_reg   <= 1'b1;
            mem_waddr_reg   <= addr_reg;
            mem_data_in_reg <= rx_data;
            addr_reg        <= addr_reg + addr_width'(1);
            len_reg         <= len_reg - 16'd1;
            if (len_reg == 16'd1) tx_data_reg <= RSP_ACK;
          end
        end
        DUMP_RD: mem_raddr_reg <= addr_reg;
        DUMP_TX: begin
          // Hold the sent byte on tx_data after leaving DUMP_TX
          tx_data_reg <= mem_data_out;
          if (!tx_busy) begin
            addr_reg <= addr_reg + addr_width'(1);
            len_reg  <= len_reg - 16'd1;
          end
        end
        RUN: start_address_reg <= addr_reg;
        RUN_WAIT: begin
          if (cpu_halted) begin
            halt_reg    <= 1'b0;
            tx_data_reg <= RSP_ACK;
          end else if (rx_valid && rx_data == CMD_HALT) begin
            halt_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. tx_start is qualified by tx_busy combinationally so a strobe can
  // never coincide with a busy transmitter; both sending states leave on the
  // strobe cycle, so the strobe lasts exactly one cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_sel       = (state_reg != RUN_WAIT);
    cpu_reset     = (state_reg != RUN_WAIT);
    cpu_halt      = halt_reg;
    tx_start      = ((state_reg == ACK) || (state_reg == DUMP_TX)) && !tx_busy;
    // Read data arrives one cycle after the address, i.e. in DUMP_TX
    tx_data       = (state_reg == DUMP_TX) ? mem_data_out : tx_data_reg;
    mem_raddr     = mem_raddr_reg;
    mem_waddr     = mem_waddr_reg;
    mem_data_in   = mem_data_in_reg;
    mem_write     = mem_write_reg && mem_sel;
    start_address = start_address_reg;
  end

endmodule
